dm_arbiter: RTL and testbench

Two-master arbiter and access sequencer for the single-port 4 KB data memory (`dm_4k`). It shares the memory between the CPU load/store port (master 0) and a DMA/debug port (master 1). Each memory access is sequenced through a fixed three-state cycle, and read data is returned in a register. Arbitration is round-robin with a bounded burst allowance so that neither master starves.

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arb_pick.sv | 28 ++
 rtl/dm_arbiter.sv | 136 +++++++++++++
 tb/tb_dm_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// State encoding, master indices and burst counter width live here.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int BURST_W = 4;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection: round-robin with a bounded burst allowance.
// The last owner keeps winning a tie until it has used MAX_BURST grants in a row.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               m0_req,
  input  logic               m1_req,
  input  logic               owner,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               grant_valid,
  output logic               winner
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  always_comb begin
    grant_valid = m0_req | m1_req;
    winner      = M0;
    if (m0_req && m1_req) begin
      winner = (burst_cnt < BURST_MAX) ? owner : ~owner;
    end else if (m1_req) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter and IDLE -> ACCESS -> ACK sequencer for the 4 KB data memory.
// Handshake: a master raises req with a stable command and holds both until its
//   one-cycle ack; ack and rdata are valid together; a req seen in IDLE is new.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic               m0_byte,
  input  logic [31:0]        m0_addr,
  input  logic [31:0]        m0_wdata,
  output logic               m0_ack,
  output logic [31:0]        m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic               m1_byte,
  input  logic [31:0]        m1_addr,
  input  logic [31:0]        m1_wdata,
  output logic               m1_ack,
  output logic [31:0]        m1_rdata,
  output logic [31:0]        dm_addr,
  output logic [31:0]        dm_din,
  output logic               dm_wr,
  output logic               dm_byte,
  input  logic [31:0]        dm_dout,
  output logic               busy,
  output logic               owner,
  output state_t             fsm_state,
  output logic [BURST_W-1:0] burst_cnt
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  state_t      state;
  state_t      state_nxt;
  logic        grant_valid;
  logic        winner;
  logic        sel_we;
  logic        sel_byte;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  dm_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .m0_req      (m0_req),
    .m1_req      (m1_req),
    .owner       (owner),
    .burst_cnt   (burst_cnt),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The owner's command is muxed only in ACCESS; the bus reads as zero otherwise.
  always_comb begin
    sel_we    = (owner == M1) ? m1_we    : m0_we;
    sel_byte  = (owner == M1) ? m1_byte  : m0_byte;
    sel_addr  = (owner == M1) ? m1_addr  : m0_addr;
    sel_wdata = (owner == M1) ? m1_wdata : m0_wdata;
  end

  always_comb begin
    busy    = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    dm_wr   = 1'b0;
    dm_byte = 1'b0;
    dm_addr = 32'h0;
    dm_din  = 32'h0;
    case (state)
      ACCESS: begin
        busy    = 1'b1;
        dm_wr   = sel_we;
        dm_byte = sel_byte;
        dm_addr = sel_addr;
        dm_din  = sel_wdata;
      end
      ACK: begin
        busy   = 1'b1;
        m0_ack = (owner == M0);
        m1_ack = (owner == M1);
      end
      default: ;
    endcase
  end

  // owner/burst_cnt reset so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      owner     <= M1;
      burst_cnt <= BURST_MAX;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      if (state == IDLE && grant_valid) begin
        owner <= winner;
        if (winner != owner) begin
          burst_cnt <= BURST_W'(1);
        end else if (burst_cnt < BURST_MAX) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end else begin
          burst_cnt <= BURST_MAX;
        end
      end
      if (state == ACCESS) begin
        if (owner == M1) m1_rdata <= dm_dout;
        else             m0_rdata <= dm_dout;
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with MAX_BURST = 2 and a behavioural dm_4k model.
// Table vectors cover single accesses; hand sequences cover arbitration and reset.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int MAX_BURST = 2;

  logic               clk = 1'b0;
  logic               clr_n = 1'b0;
  logic               m0_req = 1'b0, m0_we = 1'b0, m0_byte = 1'b0;
  logic [31:0]        m0_addr = 32'h0, m0_wdata = 32'h0;
  logic               m1_req = 1'b0, m1_we = 1'b0, m1_byte = 1'b0;
  logic [31:0]        m1_addr = 32'h0, m1_wdata = 32'h0;
  logic               m0_ack, m1_ack;
  logic [31:0]        m0_rdata, m1_rdata;
  logic [31:0]        dm_addr, dm_din, dm_dout;
  logic               dm_wr, dm_byte, busy, owner;
  state_t             fsm_state;
  logic [BURST_W-1:0] burst_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rd [2];
  logic [0:0]  exp_q [$];

  typedef struct {
    logic        m;
    logic        we;
    logic        b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  dm_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_byte(m0_byte), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_byte(m1_byte), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_byte(dm_byte),
    .dm_dout(dm_dout), .busy(busy), .owner(owner),
    .fsm_state(fsm_state), .burst_cnt(burst_cnt)
  );

  // Clock and memory model: combinational read, byte reads sign-extended.
  always #5 clk = ~clk;

  logic [31:0] mem [1024] = '{default: 32'h0};
  logic [31:0] mem_word;
  logic [7:0]  mem_lane;

  always_comb begin
    mem_word = mem[dm_addr[11:2]];
    mem_lane = mem_word[dm_addr[1:0]*8 +: 8];
    dm_dout  = dm_byte ? {{24{mem_lane[7]}}, mem_lane} : mem_word;
  end

  always @(posedge clk) begin
    if (dm_wr) begin
      if (dm_byte) mem[dm_addr[11:2]][dm_addr[1:0]*8 +: 8] <= dm_din[7:0];
      else         mem[dm_addr[11:2]] <= dm_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input logic m);
    return (m == M1) ? m1_ack : m0_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input logic m);
    return (m == M1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic drive(input logic m, input logic req, input logic we, input logic b,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == M1) begin
      m1_req = req; m1_we = we; m1_byte = b; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_byte = b; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    drive(M0, 0, 0, 0, 32'h0, 32'h0);
    drive(M1, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    check("rst_dm_wr", 32'(dm_wr), 32'h0);
    check("rst_owner", 32'(owner), 32'h1);
    check("rst_burst_cnt", 32'(burst_cnt), 32'(MAX_BURST));
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    clr_n = 1'b1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  // One isolated access: ack expected two cycles after the request cycle.
  task automatic do_access(input vec_t v, input string name);
    int lat;
    @(posedge clk);
    #1;
    drive(v.m, 1, v.we, v.b, v.addr, v.wdata);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({name, "_idle_wr"}, 32'(dm_wr), 32'h0);
        check({name, "_idle_addr"}, dm_addr, 32'h0);
      end
      if (c == 1) begin
        check({name, "_acc_state"}, 32'(fsm_state), 32'(ACCESS));
        check({name, "_acc_wr"}, 32'(dm_wr), 32'(v.we));
        check({name, "_acc_addr"}, dm_addr, v.addr);
        check({name, "_acc_din"}, dm_din, v.wdata);
        check({name, "_acc_byte"}, 32'(dm_byte), 32'(v.b));
      end
      if (ack_of(v.m)) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'h2);
    if (lat >= 0) begin
      check({name, "_rdata"}, rdata_of(v.m), v.exp_rdata);
      check({name, "_other_rdata"}, rdata_of(~v.m), exp_rd[int'(~v.m)]);
      check({name, "_other_ack"}, 32'(ack_of(~v.m)), 32'h0);
      check({name, "_ack_wr"}, 32'(dm_wr), 32'h0);
    end
    exp_rd[int'(v.m)] = v.exp_rdata;
    @(posedge clk);
    #1;
    drive(v.m, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    int acks;
    int gap;
    int last [2];
    logic [0:0] who;
    logic [0:0] exp_who;

    //          m   we b  addr          wdata         exp_rdata
    vecs[0] = '{M0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{M0, 0, 0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{M1, 1, 1, 32'h0000_0013, 32'h0000_0080, 32'hFFFF_FFDE};
    vecs[3] = '{M1, 0, 1, 32'h0000_0013, 32'h0000_0000, 32'hFFFF_FF80};
    vecs[4] = '{M0, 0, 0, 32'h0000_0010, 32'h0000_0000, 32'h80AD_BEEF};
    vecs[5] = '{M1, 0, 1, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FFEF};
    vecs[6] = '{M0, 1, 1, 32'h0000_0011, 32'h1234_5655, 32'hFFFF_FFBE};
    vecs[7] = '{M0, 0, 0, 32'h0000_0010, 32'h0000_0000, 32'h80AD_55EF};
    vecs[8] = '{M1, 1, 0, 32'h0000_0FFC, 32'h0000_007F, 32'h0000_0000};
    vecs[9] = '{M1, 0, 1, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_007F};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_access(vecs[i], $sformatf("vec%0d", i));
    end

    // Both masters request continuously: grant order 0,0,1,1,0,0.
    do_reset();
    exp_q = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    drive(M0, 1, 0, 0, 32'h010, 32'h0);
    drive(M1, 1, 0, 0, 32'h014, 32'h0);
    acks = 0;
    last[0] = 0;
    last[1] = 0;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        check("tie_single_ack", 32'(m0_ack & m1_ack), 32'h0);
        who = m1_ack;
        exp_who = exp_q.pop_front();
        check($sformatf("tie_grant%0d", acks), 32'(who), 32'(exp_who));
        gap = c - last[int'(who)];
        check($sformatf("tie_wait%0d", acks), 32'(gap <= 9), 32'h1);
        last[int'(who)] = c;
        acks++;
      end
    end
    check("tie_ack_count", 32'(acks), 32'h6);
    @(posedge clk);
    #1;
    drive(M0, 0, 0, 0, 32'h0, 32'h0);
    drive(M1, 0, 0, 0, 32'h0, 32'h0);

    // Only m1 requests, five back-to-back accesses.
    do_reset();
    @(posedge clk);
    #1;
    drive(M1, 1, 0, 1, 32'h013, 32'h0);
    acks = 0;
    for (int c = 0; c < 30 && acks < 5; c++) begin
      @(negedge clk);
      if (m1_ack) begin
        check($sformatf("solo_ack_cycle%0d", acks), 32'(c), 32'(2 + 3 * acks));
        check("solo_owner", 32'(owner), 32'h1);
        check("solo_burst", 32'(burst_cnt), 32'(MAX_BURST));
        check("solo_rdata", m1_rdata, 32'hFFFF_FF80);
        acks++;
      end
    end
    check("solo_ack_count", 32'(acks), 32'h5);
    @(posedge clk);
    #1;
    drive(M1, 0, 0, 0, 32'h0, 32'h0);

    // Reset asserted during the ACCESS cycle of a write.
    do_reset();
    do_access('{M0, 1, 0, 32'h020, 32'h1111_1111, 32'h0}, "pre_wr");
    @(posedge clk);
    #1;
    drive(M0, 1, 1'b1, 0, 32'h020, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_acc_wr", 32'(dm_wr), 32'h1);
    #1;
    clr_n = 1'b0;
    #1;
    check("mid_rst_wr_drop", 32'(dm_wr), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    drive(M0, 0, 0, 0, 32'h0, 32'h0);
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    check("mid_rst_no_ack", 32'(acks), 32'h0);
    clr_n = 1'b1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    do_access('{M0, 0, 0, 32'h020, 32'h0, 32'h1111_1111}, "post_rst_rd");

    // m0 drops req during ACCESS: access still completes with one ack.
    @(posedge clk);
    #1;
    drive(M0, 1, 0, 0, 32'h010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("drop_acc_state", 32'(fsm_state), 32'(ACCESS));
    m0_req = 1'b0;
    acks = 0;
    for (int c = 2; c < 7; c++) begin
      @(negedge clk);
      if (m0_ack) acks++;
      if (c == 2) begin
        check("drop_ack", 32'(m0_ack), 32'h1);
        check("drop_rdata", m0_rdata, 32'h80AD_55EF);
      end
      if (c == 3) begin
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_idle", 32'(fsm_state), 32'(IDLE));
      end
    end
    check("drop_ack_count", 32'(acks), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
